// File: rtl/rv_isa_pkg.sv
// ============================================================
// Module  : rv_isa_pkg
// Brief   : RV32I opcode constants, format enum and opcode decode
// Revision: 1.0
// ============================================================
`default_nettype none

package rv_isa_pkg;

    localparam logic [6:0] c_op_reg    = 7'b0110011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_system = 7'b1110011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_ILLEGAL
    } fmt_e;

    function automatic fmt_e opcode_to_fmt(input logic [6:0] op);
        fmt_e f;
        case (op)
            c_op_reg:                                    f = FMT_R;
            c_op_imm, c_op_load, c_op_jalr, c_op_system: f = FMT_I;
            c_op_store:                                  f = FMT_S;
            c_op_branch:                                 f = FMT_B;
            c_op_lui, c_op_auipc:                        f = FMT_U;
            c_op_jal:                                    f = FMT_J;
            default:                                     f = FMT_ILLEGAL;
        endcase
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_imm_packer.sv
// ============================================================
// Module  : instruction_imm_packer
// Brief   : Combinational field/immediate packing with range check
// Revision: 1.0
// ============================================================
`default_nettype none

module instruction_imm_packer
    import rv_isa_pkg::*;
(
    input  fmt_e        i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [2:0]  i_func3,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [6:0]  i_func7,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    // An immediate fits in N signed bits when bits [31:N-1] are all equal.
    logic w_fits12;
    logic w_fits13;
    logic w_fits21;

    assign w_fits12 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
    assign w_fits13 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
    assign w_fits21 = (&i_imm[31:20]) | ~(|i_imm[31:20]);

    always_comb begin
        o_word    = {i_func7, i_rs2, i_rs1, i_func3, i_rd, i_opcode};
        o_illegal = 1'b0;
        case (i_fmt)
            FMT_R: begin
                o_illegal = 1'b0;
            end
            FMT_I: begin
                o_word    = {i_imm[11:0], i_rs1, i_func3, i_rd, i_opcode};
                o_illegal = ~w_fits12;
            end
            FMT_S: begin
                o_word    = {i_imm[11:5], i_rs2, i_rs1, i_func3, i_imm[4:0], i_opcode};
                o_illegal = ~w_fits12;
            end
            FMT_B: begin
                o_word    = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_func3,
                             i_imm[4:1], i_imm[11], i_opcode};
                o_illegal = ~w_fits13 | i_imm[0];
            end
            FMT_U: begin
                o_word    = {i_imm[31:12], i_rd, i_opcode};
                o_illegal = |i_imm[11:0];
            end
            FMT_J: begin
                o_word    = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                o_illegal = ~w_fits21 | i_imm[0];
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/instruction_encoder.sv
// ============================================================
// Module  : instruction_encoder
// Brief   : Two-stage RV32I encoder with sequential word addresses
// Revision: 1.0
// ============================================================
`default_nettype none

module instruction_encoder
    import rv_isa_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [2:0]        func3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [6:0]        func7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] addr,
    output logic              illegal
);

    localparam logic [ADDR_W-1:0] c_base_addr = ADDR_W'(BASE_ADDR);

    logic              r_s1_valid;
    fmt_e              r_s1_fmt;
    logic [6:0]        r_s1_opcode;
    logic [4:0]        r_s1_rd;
    logic [2:0]        r_s1_func3;
    logic [4:0]        r_s1_rs1;
    logic [4:0]        r_s1_rs2;
    logic [6:0]        r_s1_func7;
    logic [31:0]       r_s1_imm;

    logic              r_out_valid;
    logic [31:0]       r_instruction;
    logic              r_illegal;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_next_addr;

    logic              w_s1_load;
    logic              w_s2_load;
    logic [31:0]       w_word;
    logic              w_illegal;

    assign w_s2_load = r_s1_valid && (!r_out_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_s2_load;
    assign w_s1_load = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_fmt    <= FMT_R;
            r_s1_opcode <= '0;
            r_s1_rd     <= '0;
            r_s1_func3  <= '0;
            r_s1_rs1    <= '0;
            r_s1_rs2    <= '0;
            r_s1_func7  <= '0;
            r_s1_imm    <= '0;
        end else if (w_s1_load) begin
            r_s1_valid  <= 1'b1;
            r_s1_fmt    <= opcode_to_fmt(opcode);
            r_s1_opcode <= opcode;
            r_s1_rd     <= rd;
            r_s1_func3  <= func3;
            r_s1_rs1    <= rs1;
            r_s1_rs2    <= rs2;
            r_s1_func7  <= func7;
            r_s1_imm    <= imm;
        end else if (w_s2_load) begin
            r_s1_valid  <= 1'b0;
        end
    end

    instruction_imm_packer u_packer (
        .i_fmt     (r_s1_fmt),
        .i_opcode  (r_s1_opcode),
        .i_rd      (r_s1_rd),
        .i_func3   (r_s1_func3),
        .i_rs1     (r_s1_rs1),
        .i_rs2     (r_s1_rs2),
        .i_func7   (r_s1_func7),
        .i_imm     (r_s1_imm),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    // Address is allocated when a word enters S2, so illegal words consume one too.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_instruction <= '0;
            r_illegal     <= 1'b0;
            r_addr        <= c_base_addr;
            r_next_addr   <= c_base_addr;
        end else if (w_s2_load) begin
            r_out_valid   <= 1'b1;
            r_instruction <= w_word;
            r_illegal     <= w_illegal;
            r_addr        <= r_next_addr;
            r_next_addr   <= r_next_addr + ADDR_W'(1);
        end else if (out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign instruction = r_instruction;
    assign illegal     = r_illegal;
    assign addr        = r_addr;

endmodule

`default_nettype wire

// File: tb/tb_instruction_encoder.sv
// ============================================================
// Module  : tb_instruction_encoder
// Brief   : Scoreboard bench for instruction_encoder (two address widths)
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_instruction_encoder;

    localparam int c_base_a = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  func3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  func7;
    logic [31:0] imm;

    logic        in_ready,    in_ready_w;
    logic        out_valid,   out_valid_w;
    logic [31:0] instruction, instruction_w;
    logic [9:0]  addr;
    logic [1:0]  addr_w;
    logic        illegal,     illegal_w;

    logic [32:0] q[$];
    logic [32:0] pend;
    logic [9:0]  exp_a;
    logic [1:0]  exp_w;
    int          n_pass  = 0;
    int          n_total = 0;
    int          n_acc   = 0;

    always #5 clk = ~clk;

    instruction_encoder #(.ADDR_W(10), .BASE_ADDR(c_base_a)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .func3(func3), .rs1(rs1), .rs2(rs2),
        .func7(func7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .instruction(instruction), .addr(addr), .illegal(illegal)
    );

    instruction_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
        .opcode(opcode), .rd(rd), .func3(func3), .rs1(rs1), .rs2(rs2),
        .func7(func7), .imm(imm), .out_valid(out_valid_w), .out_ready(out_ready),
        .instruction(instruction_w), .addr(addr_w), .illegal(illegal_w)
    );

    // Reference encoder: {illegal, word}
    function automatic logic [32:0] model(input logic [6:0] op, input logic [4:0] d,
                                          input logic [2:0] f3, input logic [4:0] s1,
                                          input logic [4:0] s2, input logic [6:0] f7,
                                          input logic [31:0] im);
        int s;
        logic [31:0] w;
        logic bad;
        s = $signed(im);
        w = '0;
        w[6:0] = op;
        bad = 1'b0;
        case (op)
            7'h13, 7'h03, 7'h67, 7'h73: begin
                w[11:7] = d; w[14:12] = f3; w[19:15] = s1; w[31:20] = im[11:0];
                bad = (s < -2048) || (s > 2047);
            end
            7'h23: begin
                w[11:7] = im[4:0]; w[14:12] = f3; w[19:15] = s1; w[24:20] = s2;
                w[31:25] = im[11:5];
                bad = (s < -2048) || (s > 2047);
            end
            7'h63: begin
                w[7] = im[11]; w[11:8] = im[4:1]; w[14:12] = f3; w[19:15] = s1;
                w[24:20] = s2; w[30:25] = im[10:5]; w[31] = im[12];
                bad = (s < -4096) || (s > 4095) || im[0];
            end
            7'h37, 7'h17: begin
                w[11:7] = d; w[31:12] = im[31:12];
                bad = (im[11:0] != 12'd0);
            end
            7'h6F: begin
                w[11:7] = d; w[19:12] = im[19:12]; w[20] = im[11]; w[30:21] = im[10:1];
                w[31] = im[20];
                bad = (s < -1048576) || (s > 1048575) || im[0];
            end
            default: begin
                w[11:7] = d; w[14:12] = f3; w[19:15] = s1; w[24:20] = s2; w[31:25] = f7;
                bad = (op != 7'h33);
            end
        endcase
        return {bad, w};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic put(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7,
                       input logic [31:0] im);
        opcode = op; rd = d; func3 = f3; rs1 = s1; rs2 = s2; func7 = f7; imm = im;
        in_valid = 1'b1;
        pend = model(op, d, f3, s1, s2, f7, im);
    endtask

    task automatic put_k(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7,
                         input logic [31:0] im, input logic [31:0] w, input logic ill);
        put(op, d, f3, s1, s2, f7, im);
        pend = {ill, w};
    endtask

    task automatic put_rand();
        logic [6:0] ops [11];
        int v;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
        v = $urandom_range(0, 8191) - 4096;
        put(ops[$urandom_range(0, 10)], 5'($urandom), 3'($urandom), 5'($urandom),
            5'($urandom), 7'($urandom), ($urandom_range(0, 3) == 0) ? $urandom : 32'(v));
    endtask

    // One clock: score handshakes just before the edge, return at the next negedge.
    task automatic tick();
        logic [32:0] e;
        #1;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_word", 32'(out_valid), 32'd0);
            end else begin
                e = q.pop_front();
                chk("word",      instruction,          e[31:0]);
                chk("illegal",   32'(illegal),         32'(e[32]));
                chk("addr",      32'(addr),            32'(exp_a));
                chk("word_w",    instruction_w,        e[31:0]);
                chk("illegal_w", 32'(illegal_w),       32'(e[32]));
                chk("addr_w",    32'(addr_w),          32'(exp_w));
                exp_a++;
                exp_w++;
            end
        end
        if (in_valid && in_ready) begin
            q.push_back(pend);
            n_acc++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && q.size() > 0; k++) tick();
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        exp_a = 10'(c_base_a);
        exp_w = 2'd0;
    endtask

    initial begin
        logic [31:0] held;
        int n0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; rd = '0; func3 = '0; rs1 = '0; rs2 = '0; func7 = '0; imm = '0;
        pend = '0;
        exp_a = 10'(c_base_a);
        exp_w = 2'd0;
        @(negedge clk);
        do_reset();
        chk("rst_out_valid",   32'(out_valid),   32'd0);
        chk("rst_instruction", instruction,      32'd0);
        chk("rst_illegal",     32'(illegal),     32'd0);
        chk("rst_addr",        32'(addr),        32'(c_base_a));
        chk("rst_addr_w",      32'(addr_w),      32'd0);
        chk("rst_in_ready",    32'(in_ready),    32'd1);
        chk("rst_out_valid_w", 32'(out_valid_w), 32'd0);
        chk("rst_in_ready_w",  32'(in_ready_w),  32'd1);

        // add x3,x1,x2 and its latency
        put_k(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 32'h002081B3, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
        tick();

        // back-to-back directed words, including range and opcode errors
        put_k(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5,          32'h00500093, 1'b0); tick();
        put_k(7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8,          32'h0020A423, 1'b0); tick();
        put_k(7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000,   32'h123452B7, 1'b0); tick();
        put_k(7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFFFFFC,   32'hFE208EE3, 1'b0); tick();
        put_k(7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048,       32'h001000EF, 1'b0); tick();
        put_k(7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd3,          32'h00208163, 1'b1); tick();
        put_k(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048,       32'h80000093, 1'b1); tick();
        put_k(7'h7F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0,          32'h000000FF, 1'b1); tick();
        in_valid = 1'b0;
        drain();

        // random traffic with random backpressure
        for (int i = 0; i < 30; i++) begin
            put_rand();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // full stall: two words fill S2 then S1, outputs frozen
        out_ready = 1'b0;
        n0 = n_acc;
        held = '0;
        for (int i = 0; i < 5; i++) begin
            put_rand();
            tick();
            if (i == 1) held = instruction;
            if (i >= 1) begin
                chk("stall_in_ready",  32'(in_ready),  32'd0);
                chk("stall_out_valid", 32'(out_valid), 32'd1);
            end
            if (i >= 2) chk("stall_hold", instruction, held);
        end
        chk("stall_accepted", 32'(n_acc - n0), 32'd2);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // reset in the middle of a stream
        for (int i = 0; i < 3; i++) begin
            put_rand();
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        exp_a = 10'(c_base_a);
        exp_w = 2'd0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        put_rand();
        tick();
        in_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
